// File: rtl/game_controller_if.sv
// Frame, button and position signals shared by the game sequencer and the VGA renderer.
// The controller drives positions and status (master); the renderer/board side supplies frame and buttons.
interface game_controller_if;
    logic       frame_tick;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [9:0] raccoonX;
    logic [9:0] raccoonY;
    logic [9:0] carX_1;
    logic [9:0] carY_1;
    logic [9:0] carX_2;
    logic [9:0] carY_2;
    logic [9:0] carX_3;
    logic [9:0] carY_3;
    logic [1:0] lives;
    logic [7:0] score;
    logic [1:0] game_state;

    modport master (
        input  frame_tick, btn_up, btn_down, btn_left, btn_right,
        output raccoonX, raccoonY, carX_1, carY_1, carX_2, carY_2, carX_3, carY_3,
               lives, score, game_state
    );

    modport slave (
        output frame_tick, btn_up, btn_down, btn_left, btn_right,
        input  raccoonX, raccoonY, carX_1, carY_1, carX_2, carY_2, carX_3, carY_3,
               lives, score, game_state
    );
endinterface

// File: rtl/game_controller.sv
// Frame-synchronous raccoon-crossing sequencer: raccoon moves on button press edges,
// cars, collisions and wins are resolved once per frame_tick.
//
// state | meaning
// IDLE  | waiting for first press, cars frozen
// PLAY  | raccoon steerable, cars move and collisions checked each frame
// HIT   | post-collision freeze, cars move, buttons ignored for HIT_FRAMES frames
// OVER  | no lives left, cars frozen, any press restarts
module game_controller #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int GRID       = 32,
    parameter int PLAYER_W   = 32,
    parameter int PLAYER_H   = 32,
    parameter int CAR_W      = 64,
    parameter int CAR_H      = 32,
    parameter int START_X    = 288,
    parameter int START_Y    = 448,
    parameter int CAR1_Y     = 96,
    parameter int CAR2_Y     = 192,
    parameter int CAR3_Y     = 320,
    parameter int CAR1_SPD   = 2,
    parameter int CAR2_SPD   = 3,
    parameter int CAR3_SPD   = 4,
    parameter int HIT_FRAMES = 30,
    parameter int LIVES_INIT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    game_controller_if.master  gif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_HIT  = 2'b10,
        S_OVER = 2'b11
    } state_t;

    localparam logic [10:0] H_W     = 11'(H_RES);
    localparam logic [10:0] GRID_W  = 11'(GRID);
    localparam logic [10:0] PW_W    = 11'(PLAYER_W);
    localparam logic [10:0] PH_W    = 11'(PLAYER_H);
    localparam logic [10:0] CW_W    = 11'(CAR_W);
    localparam logic [10:0] CH_W    = 11'(CAR_H);
    localparam logic [10:0] X_MAX   = 11'(H_RES - PLAYER_W);
    localparam logic [10:0] Y_MAX   = 11'(V_RES - PLAYER_H);
    localparam logic [10:0] SPD1_W  = 11'(CAR1_SPD);
    localparam logic [10:0] SPD2_W  = 11'(CAR2_SPD);
    localparam logic [10:0] SPD3_W  = 11'(CAR3_SPD);
    localparam logic [9:0]  SX      = 10'(START_X);
    localparam logic [9:0]  SY      = 10'(START_Y);
    localparam logic [9:0]  C1_X0   = 10'd0;
    localparam logic [9:0]  C2_X0   = 10'd320;
    localparam logic [9:0]  C3_X0   = 10'd160;
    localparam logic [10:0] C1_YW   = 11'(CAR1_Y);
    localparam logic [10:0] C2_YW   = 11'(CAR2_Y);
    localparam logic [10:0] C3_YW   = 11'(CAR3_Y);
    localparam logic [1:0]  LIVES_W = 2'(LIVES_INIT);
    localparam logic [7:0]  HIT_W   = 8'(HIT_FRAMES);

    state_t     state_q, state_d;
    logic [9:0] rx_q, rx_d, ry_q, ry_d;
    logic [9:0] c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
    logic [1:0] lives_q, lives_d;
    logic [7:0] score_q, score_d;
    logic [7:0] hit_q, hit_d;
    logic [3:0] btn_prev_q;

    logic [3:0]  btn, btn_edge;
    logic        any_edge;
    logic [10:0] rx_w, ry_w, c1_sum, c3_sum;
    logic [9:0]  mx, my, c1_nxt, c2_nxt, c3_nxt;
    logic        collide;

    function automatic logic overlap(input logic [10:0] rx, input logic [10:0] ry,
                                     input logic [10:0] cx, input logic [10:0] cy);
        return (rx < cx + CW_W) && (cx < rx + PW_W) && (ry < cy + CH_W) && (cy < ry + PH_W);
    endfunction

    assign btn      = {gif.btn_up, gif.btn_down, gif.btn_left, gif.btn_right};
    assign btn_edge = btn & ~btn_prev_q;
    assign any_edge = |btn_edge;
    assign rx_w     = {1'b0, rx_q};
    assign ry_w     = {1'b0, ry_q};

    // Car 2 wraps leftward without ever going negative, so every position stays below H_RES.
    assign c1_sum = {1'b0, c1_q} + SPD1_W;
    assign c3_sum = {1'b0, c3_q} + SPD3_W;
    assign c1_nxt = 10'((c1_sum >= H_W) ? c1_sum - H_W : c1_sum);
    assign c3_nxt = 10'((c3_sum >= H_W) ? c3_sum - H_W : c3_sum);
    assign c2_nxt = 10'(({1'b0, c2_q} < SPD2_W) ? {1'b0, c2_q} + H_W - SPD2_W
                                                 : {1'b0, c2_q} - SPD2_W);

    assign collide = overlap(rx_w, ry_w, {1'b0, c1_q}, C1_YW)
                   | overlap(rx_w, ry_w, {1'b0, c2_q}, C2_YW)
                   | overlap(rx_w, ry_w, {1'b0, c3_q}, C3_YW);

    // Only the highest-priority edge is considered; if it would leave the screen nothing moves.
    always_comb begin
        mx = rx_q;
        my = ry_q;
        if (btn_edge[3]) begin
            if (ry_w >= GRID_W) my = 10'(ry_w - GRID_W);
        end else if (btn_edge[2]) begin
            if (ry_w + GRID_W <= Y_MAX) my = 10'(ry_w + GRID_W);
        end else if (btn_edge[1]) begin
            if (rx_w >= GRID_W) mx = 10'(rx_w - GRID_W);
        end else if (btn_edge[0]) begin
            if (rx_w + GRID_W <= X_MAX) mx = 10'(rx_w + GRID_W);
        end
    end

    always_comb begin
        state_d = state_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        c3_d    = c3_q;
        lives_d = lives_q;
        score_d = score_q;
        hit_d   = hit_q;
        case (state_q)
            S_IDLE: begin
                if (any_edge) state_d = S_PLAY;
            end
            S_PLAY: begin
                rx_d = mx;
                ry_d = my;
                if (gif.frame_tick) begin
                    c1_d = c1_nxt;
                    c2_d = c2_nxt;
                    c3_d = c3_nxt;
                    if (collide) begin
                        lives_d = lives_q - 2'd1;
                        rx_d    = SX;
                        ry_d    = SY;
                        hit_d   = HIT_W;
                        state_d = (lives_q > 2'd1) ? S_HIT : S_OVER;
                    end else if (ry_q == 10'd0) begin
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                        rx_d = SX;
                        ry_d = SY;
                    end
                end
            end
            S_HIT: begin
                if (gif.frame_tick) begin
                    c1_d  = c1_nxt;
                    c2_d  = c2_nxt;
                    c3_d  = c3_nxt;
                    hit_d = hit_q - 8'd1;
                    if (hit_q <= 8'd1) state_d = S_PLAY;
                end
            end
            S_OVER: begin
                if (any_edge) begin
                    rx_d    = SX;
                    ry_d    = SY;
                    c1_d    = C1_X0;
                    c2_d    = C2_X0;
                    c3_d    = C3_X0;
                    lives_d = LIVES_W;
                    score_d = 8'd0;
                    state_d = S_PLAY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rx_q       <= SX;
            ry_q       <= SY;
            c1_q       <= C1_X0;
            c2_q       <= C2_X0;
            c3_q       <= C3_X0;
            lives_q    <= LIVES_W;
            score_q    <= 8'd0;
            hit_q      <= 8'd0;
            btn_prev_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            rx_q       <= rx_d;
            ry_q       <= ry_d;
            c1_q       <= c1_d;
            c2_q       <= c2_d;
            c3_q       <= c3_d;
            lives_q    <= lives_d;
            score_q    <= score_d;
            hit_q      <= hit_d;
            btn_prev_q <= btn;
        end
    end

    assign gif.raccoonX   = rx_q;
    assign gif.raccoonY   = ry_q;
    assign gif.carX_1     = c1_q;
    assign gif.carX_2     = c2_q;
    assign gif.carX_3     = c3_q;
    assign gif.carY_1     = 10'(CAR1_Y);
    assign gif.carY_2     = 10'(CAR2_Y);
    assign gif.carY_3     = 10'(CAR3_Y);
    assign gif.lives      = lives_q;
    assign gif.score      = score_q;
    assign gif.game_state = state_q;

endmodule
